// File: rtl/dmem_dump_ctrl.sv
// mMIPS data-memory port owner: passes core accesses through while running, then after HALT_PC
// streams every memory word out on a valid/ready port in address order.
module dmem_dump_ctrl #(
  parameter int          ADDR_W  = 15,
  parameter logic [31:0] HALT_PC = 32'h44,
  parameter int          CYC_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [31:0]       pc,
  output logic              cpu_en,
  input  logic              cpu_req,
  input  logic [3:0]        cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [31:0]       dump_data,
  output logic              dump_last,
  output logic              done,
  output logic [CYC_W-1:0]  cycles
);
  localparam int EW = ADDR_W + 32;

  typedef enum logic [1:0] {RUN, DRAIN, DUMP, FIN} state_t;
  state_t state, state_nx;

  logic [ADDR_W:0]       rd_ptr;
  logic                  infl;
  logic [ADDR_W-1:0]     infl_addr;
  logic [1:0][EW-1:0]    fifo;
  logic                  wr_idx, rd_idx;
  logic [1:0]            cnt;
  logic [2:0]            occ;
  logic                  issue, pop, pop_fifo, push, head_infl, halt;
  logic [EW-1:0]         head;

  assign halt      = en && (pc == HALT_PC);
  assign cpu_rdata = mem_rdata;
  assign cpu_en    = (state == RUN);
  assign done      = (state == FIN);

  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= RUN;
    else      state <= state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      RUN:     if (halt) state_nx = DRAIN;
      DRAIN:   state_nx = DUMP;
      DUMP:    if (pop && dump_last) state_nx = FIN;
      default: state_nx = state;
    endcase
  end

  // Slots in use include the read whose data is on mem_rdata right now, so at most two are open.
  assign occ = {1'b0, cnt} + {2'b0, infl};

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 4'b0;
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    issue     = 1'b0;
    case (state)
      RUN: begin
        mem_en = cpu_req & en;
        mem_we = cpu_we & {4{cpu_req & en}};
      end
      DUMP: begin
        issue    = !rd_ptr[ADDR_W] && (occ < 3'd2);
        mem_en   = issue;
        mem_addr = rd_ptr[ADDR_W-1:0];
      end
      default: ;
    endcase
  end

  // With the FIFO empty the head beat comes straight off mem_rdata, saving a cycle of latency;
  // if it is not taken it is captured and re-presented unchanged from the FIFO.
  assign head_infl  = (cnt == 2'd0);
  assign head       = head_infl ? {infl_addr, mem_rdata} : fifo[rd_idx];
  assign dump_valid = (state == DUMP) && (!head_infl || infl);
  assign dump_addr  = head[EW-1:32];
  assign dump_data  = head[31:0];
  assign dump_last  = dump_valid && (&dump_addr);
  assign pop        = dump_valid && dump_ready;
  assign pop_fifo   = pop && !head_infl;
  assign push       = infl && !(head_infl && pop);

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rd_ptr    <= '0;
      infl      <= 1'b0;
      infl_addr <= '0;
      fifo      <= '0;
      wr_idx    <= 1'b0;
      rd_idx    <= 1'b0;
      cnt       <= 2'd0;
    end else begin
      infl <= issue;
      if (issue) begin
        infl_addr <= rd_ptr[ADDR_W-1:0];
        rd_ptr    <= rd_ptr + 1'b1;
      end
      if (push) begin
        fifo[wr_idx] <= {infl_addr, mem_rdata};
        wr_idx       <= ~wr_idx;
      end
      if (pop_fifo) rd_idx <= ~rd_idx;
      cnt <= cnt + 2'(push) - 2'(pop_fifo);
    end

  always_ff @(posedge clk or negedge rst)
    if (!rst)                                 cycles <= '0;
    else if (state == RUN && en && ~&cycles) cycles <= cycles + 1'b1;

endmodule

// File: tb/tb_dmem_dump_ctrl.sv
// Bench for dmem_dump_ctrl: BRAM model, per-cycle dump scoreboard and directed run/halt/dump sequences.
module tb_dmem_dump_ctrl;
  localparam int          AW  = 13;
  localparam int          N   = 1 << AW;
  localparam logic [31:0] PAT = 32'hA5A5A5A5;

  logic clk, rst, en, cpu_en, cpu_req, mem_en, dump_valid, dump_ready, dump_last, done;
  logic [31:0] pc, cpu_wdata, cpu_rdata, mem_wdata, mem_rdata, dump_data, cycles;
  logic [3:0]  cpu_we, mem_we;
  logic [AW-1:0] cpu_addr, mem_addr, dump_addr;

  dmem_dump_ctrl #(.ADDR_W(AW), .HALT_PC(32'h44), .CYC_W(32)) dut (
    .clk(clk), .rst(rst), .en(en), .pc(pc), .cpu_en(cpu_en),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .dump_valid(dump_valid),
    .dump_ready(dump_ready), .dump_addr(dump_addr), .dump_data(dump_data),
    .dump_last(dump_last), .done(done), .cycles(cycles)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Synchronous BRAM with byte enables; preload fills word i with i^PAT.
  logic [31:0] mem [N];
  logic [31:0] wtmp;
  bit preload = 0;
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < N; i++) mem[i] <= 32'(i) ^ PAT;
    end else if (mem_en) begin
      wtmp = mem[mem_addr];
      for (int b = 0; b < 4; b++) if (mem_we[b]) wtmp[8*b +: 8] = mem_wdata[8*b +: 8];
      mem[mem_addr] <= wtmp;
      if (mem_we == 4'b0) mem_rdata <= mem[mem_addr];
    end
  end

  int n_cmp = 0, n_fail = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard: beats must arrive in address order 0..N-1 with data addr^PAT, hold while stalled,
  // and done must rise exactly one cycle after the last beat is taken.
  int exp_addr = 0, beats = 0;
  bit exp_done = 0, prev_stall = 0;
  logic [AW-1:0] prev_addr;
  logic [31:0]   prev_data;
  always @(negedge clk) begin
    if (!rst) begin
      exp_addr = 0; beats = 0; exp_done = 0; prev_stall = 0;
      chk("rst_valid", dump_valid, 0);
      chk("rst_done", done, 0);
    end else begin
      chk("done", done, exp_done);
      if (prev_stall) begin
        chk("stall_valid", dump_valid, 1);
        chk("stall_addr", dump_addr, prev_addr);
        chk("stall_data", dump_data, prev_data);
      end
      if (exp_done) chk("done_valid", dump_valid, 0);
      else if (dump_valid) begin
        chk("beat_addr", dump_addr, exp_addr[AW-1:0]);
        chk("beat_data", dump_data, 32'(exp_addr) ^ PAT);
        chk("beat_last", dump_last, exp_addr == N-1);
        if (dump_ready) begin
          beats++;
          if (exp_addr == N-1) exp_done = 1;
          exp_addr++;
        end
      end
      prev_stall = dump_valid && !dump_ready;
      prev_addr  = dump_addr;
      prev_data  = dump_data;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_done(input int lim, input bit rnd);
    int k = 0;
    while (!done && k < lim) begin
      step();
      if (rnd) dump_ready = 1'($urandom_range(0, 1));
      k++;
    end
    chk("done_timeout", done, 1);
  endtask

  initial begin
    int k;
    rst = 0; en = 0; pc = 0; cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0; dump_ready = 0;
    step(); step();
    chk("rst_cpu_en", cpu_en, 1);
    chk("rst_dump_valid", dump_valid, 0);
    chk("rst_dump_last", dump_last, 0);
    chk("rst_done", done, 0);
    chk("rst_cycles", cycles, 0);

    // RUN passthrough: write then read back address 5
    rst = 1; en = 1; cpu_req = 1; cpu_we = 4'hF; cpu_addr = 5; cpu_wdata = 32'hDEADBEEF;
    #1;
    chk("run_mem_en", mem_en, 1);
    chk("run_mem_we", mem_we, 4'hF);
    chk("run_mem_addr", mem_addr, 5);
    chk("run_mem_wdata", mem_wdata, 32'hDEADBEEF);
    step(); cpu_we = 0;
    #1 chk("run_rd_we", mem_we, 0);
    step();
    chk("run_rdata", cpu_rdata, 32'hDEADBEEF);
    chk("run_cycles", cycles, 2);

    // en=0 with HALT_PC: no halt, counter frozen, memory gated
    en = 0; pc = 32'h44; cpu_req = 1;
    #1 chk("en0_mem_en", mem_en, 0);
    repeat (3) step();
    chk("en0_cycles", cycles, 2);
    chk("en0_cpu_en", cpu_en, 1);
    chk("en0_valid", dump_valid, 0);
    cpu_req = 0; preload = 1;
    step(); preload = 0;

    // Halt edge, DRAIN, DUMP entry, first beat
    en = 1;
    step();
    chk("halt_cpu_en", cpu_en, 0);
    chk("drain_mem_en", mem_en, 0);
    chk("halt_cycles", cycles, 3);
    step();
    chk("dump0_mem_en", mem_en, 1);
    chk("dump0_mem_addr", mem_addr, 0);
    chk("dump0_mem_we", mem_we, 0);
    chk("dump0_valid", dump_valid, 0);
    dump_ready = 1; en = 0;
    step();
    chk("beat0_valid", dump_valid, 1);
    chk("beat0_addr", dump_addr, 0);
    chk("beat0_data", dump_data, 32'hA5A5A5A5);
    step();
    chk("beat1_data", dump_data, 32'hA5A5A5A4);

    // Full speed dump
    wait_done(N + 20, 0);
    chk("full_beats", beats, N);
    chk("full_cycles", cycles, 3);
    chk("full_cpu_en", cpu_en, 0);
    chk("full_mem_en", mem_en, 0);

    // Backpressure dump
    rst = 0; step(); rst = 1; en = 1; pc = 32'h44; dump_ready = 0;
    step(); pc = 0;
    chk("bp_cycles", cycles, 1);
    wait_done(4 * N, 1);
    chk("bp_beats", beats, N);

    // Reset in the middle of a dump, then restart from address 0
    rst = 0; step(); rst = 1; en = 1; pc = 32'h44; dump_ready = 1;
    step(); pc = 0;
    k = 0;
    while (beats < 100 && k < 300) begin step(); k++; end
    chk("beat100_timeout", beats >= 100, 1);
    rst = 0;
    #1;
    chk("midrst_valid", dump_valid, 0);
    chk("midrst_done", done, 0);
    chk("midrst_cpu_en", cpu_en, 1);
    step(); step();
    rst = 1; en = 1; pc = 0;
    step(); step();
    chk("rerun_cycles", cycles, 2);
    pc = 32'h44;
    step(); pc = 0;
    k = 0;
    while (!dump_valid && k < 10) begin step(); k++; end
    chk("restart_valid", dump_valid, 1);
    chk("restart_addr", dump_addr, 0);
    chk("restart_data", dump_data, 32'hA5A5A5A5);
    wait_done(N + 20, 0);
    chk("restart_beats", beats, N);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
